shared_det_response_ctrl: RTL and testbench

- Consumer of a duplicated, 2-share masked nonlinear layer (e.g. duplicated shared Chi3) and its per-share detection flags.
- Registers both data shares and the detection flags, and releases the data only if both copies agree.
- On a mismatch, suppresses the beat (zeroes both shares) and counts the fault; at a threshold it raises a sticky alarm and locks the datapath until reset.
- Sits between the duplicated S-box layer and the next round register / output stage.

---
 rtl/shared_det_response_ctrl.sv | 126 ++++++++++++
 tb/tb_shared_det_response_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_det_response_ctrl.sv
// Response stage for a duplicated 2-share masked S-box layer: releases agreeing beats,
// zeroes and counts mismatching ones, and locks the datapath once the fault threshold is hit.
module shared_det_response_ctrl #(
  parameter int unsigned SHARE_W      = 3,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned ALARM_THRESH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               port_in_valid,
  output logic               port_in_ready,
  input  logic [SHARE_W-1:0] port_data_s0_in,
  input  logic [SHARE_W-1:0] port_data_s1_in,
  input  logic [1:0]         port_det_in,
  output logic               port_out_valid,
  input  logic               port_out_ready,
  output logic [SHARE_W-1:0] port_data_s0_out,
  output logic [SHARE_W-1:0] port_data_s1_out,
  output logic               port_fault_out,
  output logic               port_alarm_out,
  output logic [CNT_W-1:0]   port_fault_cnt_out
);

  typedef enum logic [1:0] {StRun, StDrain, StLocked} state_e;

  state_e             state_q;
  logic               s1_valid_q;
  logic [SHARE_W-1:0] s1_s0_q;
  logic [SHARE_W-1:0] s1_s1_q;
  logic [1:0]         s1_det_q;
  logic               s2_valid_q;
  logic [SHARE_W-1:0] s2_s0_q;
  logic [SHARE_W-1:0] s2_s1_q;
  logic               s2_fault_q;
  logic               alarm_q;
  logic [CNT_W-1:0]   cnt_q;

  logic             s1_adv;
  logic             in_hs;
  logic             fault;
  logic [CNT_W-1:0] cnt_inc;
  logic             alarm_hit;

  assign s1_adv    = (state_q == StRun) & s1_valid_q & (~s2_valid_q | port_out_ready);
  assign in_hs     = port_in_valid & port_in_ready;
  // Only the detection flags drive the decision, never share data.
  assign fault     = ~(s1_det_q[0] & s1_det_q[1]);
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign alarm_hit = (ALARM_THRESH != 0) && (32'(cnt_inc) == ALARM_THRESH);

  assign port_in_ready      = ~rst & (state_q == StRun) & (~s1_valid_q | s1_adv);
  assign port_out_valid     = s2_valid_q;
  assign port_data_s0_out   = s2_s0_q;
  assign port_data_s1_out   = s2_s1_q;
  assign port_fault_out     = s2_fault_q;
  assign port_alarm_out     = alarm_q;
  assign port_fault_cnt_out = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      s1_valid_q <= 1'b0;
      s1_s0_q    <= '0;
      s1_s1_q    <= '0;
      s1_det_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_s0_q    <= '0;
      s2_s1_q    <= '0;
      s2_fault_q <= 1'b0;
      alarm_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (s1_adv) begin
            s2_valid_q <= 1'b1;
            // Each share is gated on its own; the shares never meet.
            s2_s0_q    <= fault ? '0 : s1_s0_q;
            s2_s1_q    <= fault ? '0 : s1_s1_q;
            s2_fault_q <= fault;
            if (fault) begin
              cnt_q <= cnt_inc;
              if (alarm_hit) begin
                state_q <= StDrain;
                alarm_q <= 1'b1;
              end
            end
          end else if (port_out_ready) begin
            s2_valid_q <= 1'b0;
          end

          // A beat accepted alongside the alarm-triggering move is dropped.
          if (s1_adv && fault && alarm_hit) begin
            s1_valid_q <= 1'b0;
          end else if (in_hs) begin
            s1_valid_q <= 1'b1;
            s1_s0_q    <= port_data_s0_in;
            s1_s1_q    <= port_data_s1_in;
            s1_det_q   <= port_det_in;
          end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
          end
        end

        StDrain: begin
          s1_valid_q <= 1'b0;
          if (port_out_ready) begin
            state_q    <= StLocked;
            s2_valid_q <= 1'b0;
            s2_s0_q    <= '0;
            s2_s1_q    <= '0;
            s2_fault_q <= 1'b0;
          end
        end

        StLocked: begin
          s1_valid_q <= 1'b0;
          s2_valid_q <= 1'b0;
        end

        default: state_q <= StLocked;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_det_response_ctrl.sv
// Directed bench for shared_det_response_ctrl; three instances cover the parameter sets.
module tb_shared_det_response_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] s0_in = '0;
  logic [2:0] s1_in = '0;
  logic [1:0] det = '0;
  logic       out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_fault, a_alarm;
  logic [2:0] a_d0, a_d1;
  logic [3:0] a_cnt;
  logic       b_in_ready, b_out_valid, b_fault, b_alarm;
  logic [2:0] b_d0, b_d1;
  logic [3:0] b_cnt;
  logic       c_in_ready, c_out_valid, c_fault, c_alarm;
  logic [2:0] c_d0, c_d1;
  logic [1:0] c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shared_det_response_ctrl #(.SHARE_W(3), .CNT_W(4), .ALARM_THRESH(1)) dut_a (
    .clk(clk), .rst(rst), .port_in_valid(in_valid), .port_in_ready(a_in_ready),
    .port_data_s0_in(s0_in), .port_data_s1_in(s1_in), .port_det_in(det),
    .port_out_valid(a_out_valid), .port_out_ready(out_ready),
    .port_data_s0_out(a_d0), .port_data_s1_out(a_d1), .port_fault_out(a_fault),
    .port_alarm_out(a_alarm), .port_fault_cnt_out(a_cnt)
  );

  shared_det_response_ctrl #(.SHARE_W(3), .CNT_W(4), .ALARM_THRESH(3)) dut_b (
    .clk(clk), .rst(rst), .port_in_valid(in_valid), .port_in_ready(b_in_ready),
    .port_data_s0_in(s0_in), .port_data_s1_in(s1_in), .port_det_in(det),
    .port_out_valid(b_out_valid), .port_out_ready(out_ready),
    .port_data_s0_out(b_d0), .port_data_s1_out(b_d1), .port_fault_out(b_fault),
    .port_alarm_out(b_alarm), .port_fault_cnt_out(b_cnt)
  );

  shared_det_response_ctrl #(.SHARE_W(3), .CNT_W(2), .ALARM_THRESH(0)) dut_c (
    .clk(clk), .rst(rst), .port_in_valid(in_valid), .port_in_ready(c_in_ready),
    .port_data_s0_in(s0_in), .port_data_s1_in(s1_in), .port_det_in(det),
    .port_out_valid(c_out_valid), .port_out_ready(out_ready),
    .port_data_s0_out(c_d0), .port_data_s1_out(c_d1), .port_fault_out(c_fault),
    .port_alarm_out(c_alarm), .port_fault_cnt_out(c_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic beat(input logic [2:0] a, input logic [2:0] b, input logic [1:0] d);
    in_valid = 1'b1;
    s0_in = a;
    s1_in = b;
    det = d;
  endtask

  // Test 2 / test 5 tables (hand-computed)
  logic [2:0] t2_in0 [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [2:0] t2_in1 [4] = '{3'd5, 3'd6, 3'd7, 3'd0};
  logic [1:0] t2_det [4] = '{2'b11, 2'b10, 2'b11, 2'b11};
  logic [2:0] t2_out0 [4] = '{3'd1, 3'd0, 3'd3, 3'd4};
  logic [2:0] t2_out1 [4] = '{3'd5, 3'd0, 3'd7, 3'd0};
  logic       t2_flt [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0] t2_cnt [4] = '{4'd0, 4'd1, 4'd1, 4'd1};
  logic [1:0] t5_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", 32'(a_in_ready), 0);
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_alarm", 32'(a_alarm), 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    do_reset();
    #1;
    chk("post_rst_in_ready", 32'(a_in_ready), 1);

    // 1. Clean stream
    out_ready = 1'b1;
    beat(3'b101, 3'b011, 2'b11);
    cycle();
    chk("t1_lat_not_early", 32'(a_out_valid), 0);
    cycle();
    chk("t1_b1_valid", 32'(a_out_valid), 1);
    chk("t1_b1_s0", 32'(a_d0), 5);
    chk("t1_b1_s1", 32'(a_d1), 3);
    chk("t1_b1_fault", 32'(a_fault), 0);
    cycle();
    in_valid = 1'b0;
    chk("t1_b2_valid", 32'(a_out_valid), 1);
    chk("t1_b2_s0", 32'(a_d0), 5);
    cycle();
    chk("t1_b3_valid", 32'(a_out_valid), 1);
    chk("t1_b3_s1", 32'(a_d1), 3);
    cycle();
    chk("t1_drained", 32'(a_out_valid), 0);
    chk("t1_cnt", 32'(a_cnt), 0);
    chk("t1_alarm", 32'(a_alarm), 0);

    // 4. Backpressure
    out_ready = 1'b0;
    beat(3'd1, 3'd6, 2'b11);
    #1;
    chk("t4_rdy0", 32'(a_in_ready), 1);
    cycle();
    beat(3'd2, 3'd5, 2'b11);
    #1;
    chk("t4_rdy1", 32'(a_in_ready), 1);
    cycle();
    beat(3'd7, 3'd0, 2'b11);
    #1;
    chk("t4_rdy_drop", 32'(a_in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_hold_valid", 32'(a_out_valid), 1);
      chk("t4_hold_s0", 32'(a_d0), 1);
      chk("t4_hold_s1", 32'(a_d1), 6);
      chk("t4_hold_rdy", 32'(a_in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_rdy_release", 32'(a_in_ready), 1);
    cycle();
    in_valid = 1'b0;
    chk("t4_b2_s0", 32'(a_d0), 2);
    chk("t4_b2_s1", 32'(a_d1), 5);
    cycle();
    chk("t4_b3_valid", 32'(a_out_valid), 1);
    chk("t4_b3_s0", 32'(a_d0), 7);
    cycle();
    chk("t4_empty", 32'(a_out_valid), 0);

    // 2. Single fault, threshold 3
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) beat(t2_in0[k], t2_in1[k], t2_det[k]);
      else in_valid = 1'b0;
      cycle();
      if (k >= 1) begin
        chk("t2_valid", 32'(b_out_valid), 1);
        chk("t2_s0", 32'(b_d0), 32'(t2_out0[k-1]));
        chk("t2_s1", 32'(b_d1), 32'(t2_out1[k-1]));
        chk("t2_fault", 32'(b_fault), 32'(t2_flt[k-1]));
        chk("t2_cnt", 32'(b_cnt), 32'(t2_cnt[k-1]));
        chk("t2_alarm", 32'(b_alarm), 0);
      end
    end

    // 5. Counter saturation, alarm disabled
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) beat(3'd6, 3'd3, 2'b00);
      else in_valid = 1'b0;
      cycle();
      if (k >= 1) begin
        chk("t5_cnt", 32'(c_cnt), 32'(t5_cnt[k-1]));
        chk("t5_fault", 32'(c_fault), 1);
        chk("t5_s0", 32'(c_d0), 0);
        chk("t5_s1", 32'(c_d1), 0);
        chk("t5_alarm", 32'(c_alarm), 0);
      end
    end

    // 3. Alarm path, threshold 1
    do_reset();
    beat(3'd6, 3'd1, 2'b01);
    cycle();
    beat(3'd5, 3'd3, 2'b11);
    #1;
    chk("t3_rdy_trigger_cycle", 32'(a_in_ready), 1);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_drain_valid", 32'(a_out_valid), 1);
      chk("t3_drain_s0", 32'(a_d0), 0);
      chk("t3_drain_s1", 32'(a_d1), 0);
      chk("t3_drain_fault", 32'(a_fault), 1);
      chk("t3_drain_alarm", 32'(a_alarm), 1);
      chk("t3_drain_rdy", 32'(a_in_ready), 0);
      chk("t3_drain_cnt", 32'(a_cnt), 1);
      if (i < 2) cycle();
    end
    out_ready = 1'b1;
    cycle();
    beat(3'd5, 3'd3, 2'b11);
    for (int i = 0; i < 3; i++) begin
      chk("t3_lock_valid", 32'(a_out_valid), 0);
      chk("t3_lock_fault", 32'(a_fault), 0);
      chk("t3_lock_alarm", 32'(a_alarm), 1);
      chk("t3_lock_rdy", 32'(a_in_ready), 0);
      chk("t3_lock_cnt", 32'(a_cnt), 1);
      cycle();
    end
    in_valid = 1'b0;

    // 6. Reset while in DRAIN with S2 full
    do_reset();
    beat(3'd6, 3'd1, 2'b00);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("t6_pre_alarm", 32'(a_alarm), 1);
    chk("t6_pre_valid", 32'(a_out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(a_out_valid), 0);
    chk("t6_rst_alarm", 32'(a_alarm), 0);
    chk("t6_rst_fault", 32'(a_fault), 0);
    chk("t6_rst_cnt", 32'(a_cnt), 0);
    chk("t6_rst_rdy", 32'(a_in_ready), 0);
    cycle();
    rst = 1'b0;
    #1;
    chk("t6_run_rdy", 32'(a_in_ready), 1);
    out_ready = 1'b1;
    beat(3'd2, 3'd4, 2'b11);
    cycle();
    in_valid = 1'b0;
    chk("t6_lat_not_early", 32'(a_out_valid), 0);
    cycle();
    chk("t6_valid", 32'(a_out_valid), 1);
    chk("t6_s0", 32'(a_d0), 2);
    chk("t6_s1", 32'(a_d1), 4);
    chk("t6_fault", 32'(a_fault), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
